// File: rtl/seq_age_arbiter_if.sv
// Requester, grant and commit signals of the sequence-age arbiter.
// The master drives requests, commits and grant_rdy; the slave is the arbiter.
interface seq_age_arbiter_if #(
   parameter int p_num_reqs     = 4,
   parameter int p_seq_num_bits = 5,
   parameter int p_data_bits    = 32
);
   localparam int c_idx_bits = $clog2(p_num_reqs);

   logic                                 commit_val;
   logic [p_seq_num_bits-1:0]            commit_seq_num;

   logic [p_num_reqs-1:0]                req_val;
   logic [p_num_reqs-1:0]                req_rdy;
   logic [p_num_reqs*p_seq_num_bits-1:0] req_seq_num;
   logic [p_num_reqs*p_data_bits-1:0]    req_data;

   logic                                 grant_val;
   logic                                 grant_rdy;
   logic [p_seq_num_bits-1:0]            grant_seq_num;
   logic [p_data_bits-1:0]               grant_data;
   logic [c_idx_bits-1:0]                grant_idx;

   modport master (
      output commit_val, commit_seq_num,
      output req_val, req_seq_num, req_data,
      input  req_rdy,
      input  grant_val, grant_seq_num, grant_data, grant_idx,
      output grant_rdy
   );

   modport slave (
      input  commit_val, commit_seq_num,
      input  req_val, req_seq_num, req_data,
      output req_rdy,
      input  grant_rdy,
      output grant_val, grant_seq_num, grant_data, grant_idx
   );
endinterface

// File: rtl/seq_age_arbiter.sv
// Picks the oldest valid requester relative to a wrapping "oldest in flight"
// pointer and hands it to a single-entry output register with full throughput.
module seq_age_arbiter #(
   parameter int p_num_reqs     = 4,
   parameter int p_seq_num_bits = 5,
   parameter int p_data_bits    = 32
) (
   input  logic              clk,
   input  logic              rst,
   seq_age_arbiter_if.slave  bus
);
   localparam int c_idx_bits = $clog2(p_num_reqs);

   logic [p_seq_num_bits-1:0] oldest_reg;
   logic [p_seq_num_bits-1:0] oldest_next;

   logic                      grant_val_reg;
   logic [p_seq_num_bits-1:0] grant_seq_num_reg;
   logic [p_data_bits-1:0]    grant_data_reg;
   logic [c_idx_bits-1:0]     grant_idx_reg;

   logic [p_seq_num_bits-1:0] seq_arr  [p_num_reqs];
   logic [p_data_bits-1:0]    data_arr [p_num_reqs];

   logic                      sel_found;
   logic [c_idx_bits-1:0]     sel_idx;
   logic [p_seq_num_bits-1:0] sel_seq;
   logic [p_data_bits-1:0]    sel_data;

   logic                      out_open;
   logic                      load_en;
   logic [p_num_reqs-1:0]     req_rdy_w;

   genvar gi;
   generate
      for (gi = 0; gi < p_num_reqs; gi++) begin : gen_unpack
         assign seq_arr[gi]  = bus.req_seq_num[gi*p_seq_num_bits +: p_seq_num_bits];
         assign data_arr[gi] = bus.req_data[gi*p_data_bits +: p_data_bits];
      end
   endgenerate

   // Wrapping age order: each term that lies below the oldest pointer flips the plain compare.
   function automatic logic is_older(
      input logic [p_seq_num_bits-1:0] a,
      input logic [p_seq_num_bits-1:0] b,
      input logic [p_seq_num_bits-1:0] base
   );
      return (a < b) ^ (a < base) ^ (b < base);
   endfunction

   always_comb begin
      oldest_next = oldest_reg;
      if (bus.commit_val) begin
         oldest_next = bus.commit_seq_num + 1'b1;
      end
   end

   // Strictly-older test keeps the lowest index on equal sequence numbers.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_seq   = '0;
      sel_data  = '0;
      for (int i = 0; i < p_num_reqs; i++) begin
         if (bus.req_val[i] && (!sel_found || is_older(seq_arr[i], sel_seq, oldest_reg))) begin
            sel_found = 1'b1;
            sel_idx   = i[c_idx_bits-1:0];
            sel_seq   = seq_arr[i];
            sel_data  = data_arr[i];
         end
      end
   end

   assign out_open = !grant_val_reg || bus.grant_rdy;
   assign load_en  = out_open && sel_found && !rst;

   generate
      for (gi = 0; gi < p_num_reqs; gi++) begin : gen_rdy
         assign req_rdy_w[gi] = load_en && (sel_idx == c_idx_bits'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         oldest_reg        <= '0;
         grant_val_reg     <= 1'b0;
         grant_seq_num_reg <= '0;
         grant_data_reg    <= '0;
         grant_idx_reg     <= '0;
      end else begin
         oldest_reg <= oldest_next;
         if (out_open) begin
            grant_val_reg <= sel_found;
            if (sel_found) begin
               grant_seq_num_reg <= sel_seq;
               grant_data_reg    <= sel_data;
               grant_idx_reg     <= sel_idx;
            end
         end
      end
   end

   assign bus.req_rdy       = req_rdy_w;
   assign bus.grant_val     = grant_val_reg;
   assign bus.grant_seq_num = grant_seq_num_reg;
   assign bus.grant_data    = grant_data_reg;
   assign bus.grant_idx     = grant_idx_reg;
endmodule

// File: doc/seq_age_arbiter.md
SEQ_AGE_ARBITER -- requirements
Module: seq_age_arbiter

Interface
REQ-001 Parameter: p_num_reqs, default 4, number of requesters (>=2).
REQ-002 Parameter: p_seq_num_bits, default 5, sequence number width.
REQ-003 Parameter: p_data_bits, default 32, payload width.
REQ-004 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 commit_val  input  1  an instruction commits this cycle.
REQ-008 commit_seq_num  input  p_seq_num_bits  sequence number of the committing instruction.
REQ-009 req_val  input  p_num_reqs  per-requester valid.
REQ-010 req_rdy  output  p_num_reqs  per-requester ready, one-hot or zero.
REQ-011 req_seq_num  input  p_num_reqs*p_seq_num_bits  per-requester sequence number, requester i at bits [i*W +: W].
REQ-012 req_data  input  p_num_reqs*p_data_bits  per-requester payload, packed as in REQ-011.
REQ-013 grant_val  output  1  output register holds a granted request.
REQ-014 grant_rdy  input  1  downstream accepts the grant.
REQ-015 grant_seq_num  output  p_seq_num_bits  sequence number of the granted request.
REQ-016 grant_data  output  p_data_bits  payload of the granted request.
REQ-017 grant_idx  output  $clog2(p_num_reqs)  index of the granted requester.

Function
REQ-018 The block SHALL hold register oldest, p_seq_num_bits wide: reset to 0; when commit_val=1, load commit_seq_num+1 modulo 2^p_seq_num_bits (all-ones wraps to 0); otherwise hold.
REQ-019 Age compare SHALL be "a older than b" = (a<b) XOR (a<oldest) XOR (b<oldest), unsigned, using the registered oldest value; a commit in cycle t SHALL affect comparisons from cycle t+1 only.
REQ-020 Among requesters with req_val=1, the block SHALL select the oldest per REQ-019; on equal sequence numbers the lowest index SHALL win.
REQ-021 The output register SHALL be "open" when grant_val=0, or when grant_val=1 and grant_rdy=1.
REQ-022 When open and any req_val=1, req_rdy SHALL be asserted only for the selected requester in the same cycle, combinationally; its seq_num, data and index SHALL be loaded into the output register at the clock edge, and grant_val SHALL be 1 next cycle.
REQ-023 When open and no req_val=1, req_rdy SHALL be all zero and grant_val SHALL become 0 next cycle.
REQ-024 When not open, req_rdy SHALL be all zero and the output register SHALL hold all fields stable.
REQ-025 Dequeue and enqueue in the same cycle SHALL be supported, giving full throughput of one grant per cycle with 1-cycle latency from req_val to grant_val.
REQ-026 req_rdy SHALL NOT depend on req_data; it SHALL depend on grant_rdy (pass-through when full).
REQ-027 A requester SHALL keep req_val, req_seq_num and req_data stable until accepted; the block SHALL NOT rely on this for correctness.
REQ-028 When the selected requester is not accepted because the register is not open, selection SHALL be re-evaluated next cycle, so a newly arrived older request may overtake it.

Reset
REQ-029 During rst: grant_val=0, req_rdy=0, oldest=0; grant_seq_num, grant_data and grant_idx SHALL reset to 0.
REQ-030 rst SHALL take priority over commit_val, req_val and grant_rdy in the same cycle; an in-flight grant SHALL be discarded without handshake.

Verification
REQ-031 Basic: oldest=0, req_val=4'b0110, req_seq_num[1]=7, req_seq_num[2]=3 -> req_rdy=4'b0100; next cycle grant_val=1, grant_seq_num=3, grant_idx=2.
REQ-032 Wrap: commit 27 (oldest=28), requesters 0:30, 1:2, 3:29 valid -> req_rdy selects requester 3 (29), then requester 0 (30), then requester 1 (2), one grant per cycle with grant_rdy=1.
REQ-033 Backpressure: grant_val=1, grant_rdy=0 for 3 cycles with req_val=4'b1111 -> req_rdy=0 and grant fields stable; grant_rdy=1 -> dequeue and the oldest pending request loads in the same cycle.
REQ-034 Commit timing: commit_val=1, commit_seq_num=31 together with requests 0:31 and 1:0 in the same cycle -> the compare uses the old oldest value; the next cycle uses oldest=0.
REQ-035 Tie: requesters 1 and 3 both with seq_num 5 -> requester 1 is granted first.
REQ-036 Reset mid-operation: grant_val=1 and rst asserted with grant_rdy=0 -> next cycle grant_val=0, oldest=0, req_rdy=0 while rst is high.
